// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared types and constants for the iterative multiply/divide unit.
//   mdu_op_t    : operation requested by the E-stage instruction
//   mdu_state_t : sequencer state (IDLE / BUSY / DONE)
//   MDU_ITER    : default operand width, which is also the iteration count
package mdu_pkg;

  localparam int MDU_ITER = 32;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if -- E-stage request / result bundle for the multiply/divide unit.
//   valid, op, a, b : instruction in E and its operands
//   stallE, flushE  : hazard-unit controls for the E stage
//   e_wait          : unit needs more cycles (drives the stall of F..E)
//   done, hi, lo    : result for the current E instruction
// Modports: master = pipeline/hazard side, slave = the unit.
interface mdu_iter_if import mdu_pkg::*; #(
  parameter int WIDTH = MDU_ITER
);
  logic             valid;
  mdu_op_t          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stallE;
  logic             flushE;
  logic             e_wait;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output valid, op, a, b, stallE, flushE,
    input  e_wait, done, hi, lo
  );

  modport slave (
    input  valid, op, a, b, stallE, flushE,
    output e_wait, done, hi, lo
  );
endinterface

// File: rtl/mdu_div_step.sv
// mdu_div_step -- one combinational restoring-division iteration.
//   rem, quo    : partial remainder and dividend/quotient shift register
//   divisor     : divisor magnitude
//   rem_nx      : next partial remainder
//   quo_nx      : quo shifted left with the new quotient bit in bit 0
// Relies on the loop invariant rem < divisor (or divisor == 0), so the
// trial subtraction never exceeds WIDTH bits and its top bit is the borrow.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nx,
  output logic [WIDTH-1:0] quo_nx
);
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;
  logic           fits;

  assign trial  = {rem, quo[WIDTH-1]};
  assign diff   = trial - {1'b0, divisor};
  assign fits   = ~diff[WIDTH];
  assign rem_nx = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nx = {quo[WIDTH-2:0], fits};
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter -- iterative MULT/MULTU/DIV/DIVU unit for the execute stage.
//   clk, resetn : clock, asynchronous active-low reset
//   bus (slave) : valid/op/a/b/stallE/flushE in; e_wait/done/hi/lo out
// Operates on magnitudes and applies the sign fixup on the way into DONE.
// Multiply is shift-add with a left-shifting multiplicand, one multiplier
// bit per cycle; divide uses mdu_div_step. Issue is cycle 0, done rises at
// cycle WIDTH+1.
// Build option MDU_EARLY_OUT_EN: multiplies finish as soon as the remaining
// multiplier bits are zero (minimum 2 cycles of e_wait). Division latency
// is fixed either way.
module mdu_iter import mdu_pkg::*; #(
  parameter int WIDTH = MDU_ITER
) (
  input  logic       clk,
  input  logic       resetn,
  mdu_iter_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdu_state_t         state, state_nx;
  logic [CW-1:0]      cnt;
  mdu_op_t            op_q;
  logic               neg_q;   // negate product / quotient at the end
  logic               sa_q;    // remainder takes this sign (DIV only)

  logic [2*WIDTH-1:0] mc, prod, prod_nx, prod_fix;
  logic [WIDTH-1:0]   mp;
  logic [WIDTH-1:0]   rem, quo, dvsr, rem_nx, quo_nx, rem_fix, quo_fix;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   a_mag, b_mag;

  logic start, is_sgn, is_mul, last, early, fin;
  logic neg_in, sa_in;
  logic e_wait_c, done_c;

  // ---------------------------------------------------------------- issue
  assign start  = bus.valid && !bus.flushE &&
                  (bus.op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU});
  assign is_sgn = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
  assign a_mag  = (is_sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag  = (is_sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Divide by zero must leave lo all-ones, so the quotient is never negated.
  assign neg_in = is_sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) &&
                  !((bus.op == MDU_DIV) && (bus.b == '0));
  assign sa_in  = (bus.op == MDU_DIV) && bus.a[WIDTH-1];

  // ------------------------------------------------------------ datapath
  assign is_mul  = (op_q == MDU_MULT) || (op_q == MDU_MULTU);
  assign prod_nx = prod + (mp[0] ? mc : '0);

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (dvsr),
    .rem_nx  (rem_nx),
    .quo_nx  (quo_nx)
  );

  assign last = (cnt == CW'(WIDTH - 1));

`ifdef MDU_EARLY_OUT_EN
  // The multiplicand is pre-shifted, so once no multiplier bits remain the
  // partial product is already in its final position.
  assign early = is_mul && (mp[WIDTH-1:1] == '0);
`else
  assign early = 1'b0;
`endif

  assign fin = last || early;

  assign prod_fix = neg_q ? -prod_nx : prod_nx;
  assign quo_fix  = neg_q ? -quo_nx  : quo_nx;
  assign rem_fix  = sa_q  ? -rem_nx  : rem_nx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      op_q  <= MDU_NONE;
      neg_q <= 1'b0;
      sa_q  <= 1'b0;
      mc    <= '0;
      mp    <= '0;
      prod  <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt   <= '0;
          op_q  <= bus.op;
          neg_q <= neg_in;
          sa_q  <= sa_in;
          mc    <= {{WIDTH{1'b0}}, a_mag};
          mp    <= b_mag;
          prod  <= '0;
          rem   <= '0;
          quo   <= a_mag;
          dvsr  <= b_mag;
        end
        BUSY: if (!bus.flushE) begin
          cnt  <= cnt + 1'b1;
          mc   <= mc << 1;
          mp   <= mp >> 1;
          prod <= prod_nx;
          rem  <= rem_nx;
          quo  <= quo_nx;
          if (fin) begin
            if (is_mul) begin
              {hi_q, lo_q} <= prod_fix;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // stallE is only honoured in DONE: in BUSY the stall is our own e_wait.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = BUSY;
      BUSY: begin
        if (bus.flushE)  state_nx = IDLE;
        else if (fin)    state_nx = DONE;
      end
      DONE: if (bus.flushE || !bus.stallE) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    e_wait_c = 1'b0;
    done_c   = 1'b0;
    case (state)
      IDLE:    e_wait_c = start;
      BUSY:    e_wait_c = !bus.flushE;
      DONE:    done_c   = 1'b1;
      default: ;
    endcase
    // Keep e_wait quiet while reset is asserted even if valid is high.
    if (!resetn) e_wait_c = 1'b0;
  end

  assign bus.e_wait = e_wait_c;
  assign bus.done   = done_c;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
endmodule
